// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: scan states, blank pattern and the BCD decode table.
package seg7_pkg;

  typedef enum logic [0:0] {GUARD, DRIVE} scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} codes indexed by nibble; A-F light nothing.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Purely combinational BCD nibble to active-low seven-segment decoder.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = ~SEG_TABLE[i_nibble];
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Scans an 8-digit common-anode display one digit at a time with dark guard gaps,
// swapping in newly loaded frames only at the end of a full scan.
module seven_segment_scan_controller
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYC  = 100_000,
  parameter int GUARD_CYC  = 1_000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    ready,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int TMAX = (DIGIT_CYC > GUARD_CYC) ? DIGIT_CYC : GUARD_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [TW-1:0]         DIGIT_LAST    = TW'(DIGIT_CYC - 1);
  localparam logic [TW-1:0]         GUARD_LAST    = TW'(GUARD_CYC - 1);
  localparam logic [IW-1:0]         IDX_LAST      = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT0_ONEHOT = NUM_DIGITS'(1);

  scan_state_t             r_state, w_stateNext;
  logic [TW-1:0]           r_timer, w_timerNext;
  logic [IW-1:0]           r_idx, w_idxNext;
  logic [4*NUM_DIGITS-1:0] r_actValue, w_actValueNext;
  logic [NUM_DIGITS-1:0]   r_actEn, w_actEnNext;
  logic [NUM_DIGITS-1:0]   r_actDp, w_actDpNext;
  logic [4*NUM_DIGITS-1:0] r_pendValue, w_pendValueNext;
  logic [NUM_DIGITS-1:0]   r_pendEn, w_pendEnNext;
  logic [NUM_DIGITS-1:0]   r_pendDp, w_pendDpNext;
  logic                    r_pending, w_pendingNext;
  logic                    r_ready;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [3:0]              w_nibble;
  logic [6:0]              w_segDecoded;

  // Next scan position and frame contents; the pending frame only moves to active as
  // the last digit's drive period ends, so a scan never mixes two frames.
  always_comb begin
    w_stateNext     = r_state;
    w_timerNext     = r_timer + 1'b1;
    w_idxNext       = r_idx;
    w_actValueNext  = r_actValue;
    w_actEnNext     = r_actEn;
    w_actDpNext     = r_actDp;
    w_pendValueNext = r_pendValue;
    w_pendEnNext    = r_pendEn;
    w_pendDpNext    = r_pendDp;
    w_pendingNext   = r_pending;

    case (r_state)
      GUARD: begin
        if (r_timer == GUARD_LAST) begin
          w_stateNext = DRIVE;
          w_timerNext = '0;
        end
      end
      DRIVE: begin
        if (r_timer == DIGIT_LAST) begin
          w_stateNext = GUARD;
          w_timerNext = '0;
          w_idxNext   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          if (r_idx == IDX_LAST && r_pending) begin
            w_actValueNext = r_pendValue;
            w_actEnNext    = r_pendEn;
            w_actDpNext    = r_pendDp;
            w_pendingNext  = 1'b0;
          end
        end
      end
      default: w_stateNext = GUARD;
    endcase

    if (load && r_ready) begin
      w_pendValueNext = value;
      w_pendEnNext    = digit_en;
      w_pendDpNext    = dp_in;
      w_pendingNext   = 1'b1;
    end
  end

  // Outputs are decoded from the next position so they line up with the state register.
  always_comb begin
    w_nibble = w_actValueNext[{w_idxNext, 2'b00} +: 4];
  end

  bcd_to_seg7 u_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_segDecoded)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= GUARD;
      r_timer     <= '0;
      r_idx       <= '0;
      r_actValue  <= '0;
      r_actEn     <= '0;
      r_actDp     <= '0;
      r_pendValue <= '0;
      r_pendEn    <= '0;
      r_pendDp    <= '0;
      r_pending   <= 1'b0;
      r_ready     <= 1'b1;
      r_an        <= '1;
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
    end else begin
      r_state     <= w_stateNext;
      r_timer     <= w_timerNext;
      r_idx       <= w_idxNext;
      r_actValue  <= w_actValueNext;
      r_actEn     <= w_actEnNext;
      r_actDp     <= w_actDpNext;
      r_pendValue <= w_pendValueNext;
      r_pendEn    <= w_pendEnNext;
      r_pendDp    <= w_pendDpNext;
      r_pending   <= w_pendingNext;
      r_ready     <= !w_pendingNext;
      if (w_stateNext == DRIVE) begin
        r_an  <= w_actEnNext[w_idxNext] ? ~(DIGIT0_ONEHOT << w_idxNext) : '1;
        r_seg <= w_segDecoded;
        r_dp  <= ~w_actDpNext[w_idxNext];
      end else begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end
    end
  end

  assign ready = r_ready;
  assign an    = r_an;
  assign seg   = r_seg;
  assign dp    = r_dp;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Randomised and directed bench for the scan controller, checked against a scan-position model.
module tb_seven_segment_scan_controller;

  localparam int DIGIT_LEN = 10;
  localparam int GUARD_LEN = 2;
  localparam int SLOT      = DIGIT_LEN + GUARD_LEN;
  localparam int SCAN      = 8 * SLOT;

  localparam logic [6:0] DIGIT_CODE [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  digitEn = '0;
  logic [7:0]  dpIn = '0;
  logic        ready;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  seven_segment_scan_controller #(
    .DIGIT_CYC  (DIGIT_LEN),
    .GUARD_CYC  (GUARD_LEN),
    .NUM_DIGITS (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .digit_en (digitEn),
    .dp_in    (dpIn),
    .ready    (ready),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  // Model: mT counts clock edges since reset; the scan position is plain modular arithmetic.
  int          mT;
  logic [31:0] mActVal, mPendVal;
  logic [7:0]  mActEn, mActDp, mPendEn, mPendDp;
  bit          mPending;

  logic [7:0]  expAn;
  logic [6:0]  expSeg;
  logic        expDp, expReady;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mT = 0; mPending = 0;
      mActVal = '0; mActEn = '0; mActDp = '0;
      mPendVal = '0; mPendEn = '0; mPendDp = '0;
    end else begin
      if (((mT + 1) % SCAN) == 0 && mPending) begin
        mActVal = mPendVal; mActEn = mPendEn; mActDp = mPendDp;
        mPending = 0;
      end else if (load && !mPending) begin
        mPendVal = value; mPendEn = digitEn; mPendDp = dpIn;
        mPending = 1;
      end
      mT++;
    end
  end

  function automatic int curDigit();
    return (mT % SCAN) / SLOT;
  endfunction

  function automatic int curPhase();
    return mT % SLOT;
  endfunction

  function automatic void calcExp();
    int d;
    logic [3:0] nib;
    d = curDigit();
    nib = mActVal[4*d +: 4];
    expReady = !mPending;
    if (curPhase() < GUARD_LEN) begin
      expAn = 8'hFF; expSeg = 7'h7F; expDp = 1'b1;
    end else begin
      expAn  = mActEn[d] ? ~(8'h01 << d) : 8'hFF;
      expSeg = (nib <= 4'd9) ? ~DIGIT_CODE[nib] : 7'h7F;
      expDp  = ~mActDp[d];
    end
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3*SCAN; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    waitCycles(3);
    nTests++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_hold: got an=%h seg=%h dp=%b ready=%b, want an=FF seg=7F dp=1 ready=1", an, seg, dp, ready);
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      calcExp(); nTests++;
      if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
        nFail++;
        $display("[TB] FAIL reset_release t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
      end
      if (i == 1) begin
        nTests++;
        if (seg !== 7'h7F) begin nFail++; $display("[TB] FAIL reset_guard: got seg=%h, want 7F", seg); end
      end
      if (i == 2) begin
        nTests++;
        if (seg !== 7'h40 || an !== 8'hFF) begin
          nFail++; $display("[TB] FAIL first_drive: got an=%h seg=%h, want an=FF seg=40", an, seg);
        end
      end
    end
  endtask

  task automatic test_decode();
    bit ok;
    int feCount;
    load = 1'b1; value = 32'h8765_4321; digitEn = 8'hFF; dpIn = 8'h00;
    @(negedge clk);
    load = 1'b0;
    calcExp(); nTests++;
    if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
      nFail++;
      $display("[TB] FAIL decode_load t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
    end
    waitReady(ok);
    nTests++;
    if (!ok) begin nFail++; $display("[TB] FAIL decode_swap_timeout: got ready=%b, want 1", ready); end
    feCount = 0;
    for (int i = 0; i < SCAN; i++) begin
      @(negedge clk);
      calcExp(); nTests++;
      if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
        nFail++;
        $display("[TB] FAIL decode_scan t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
      end
      if (an === 8'hFE) feCount++;
      if (curPhase() == 6) begin
        case (curDigit())
          0: begin nTests++; if (an !== 8'hFE || seg !== 7'h79) begin nFail++; $display("[TB] FAIL digit0: got an=%h seg=%h, want FE 79", an, seg); end end
          3: begin nTests++; if (an !== 8'hF7 || seg !== 7'h19) begin nFail++; $display("[TB] FAIL digit3: got an=%h seg=%h, want F7 19", an, seg); end end
          7: begin nTests++; if (an !== 8'h7F || seg !== 7'h00) begin nFail++; $display("[TB] FAIL digit7: got an=%h seg=%h, want 7F 00", an, seg); end end
          default: ;
        endcase
      end
    end
    nTests++;
    if (feCount != DIGIT_LEN) begin nFail++; $display("[TB] FAIL digit0_dwell: got %0d cycles, want %0d", feCount, DIGIT_LEN); end
  endtask

  task automatic test_blank();
    bit ok;
    for (int k = 0; k < 2; k++) begin
      load = 1'b1; value = 32'h7654_3A10; digitEn = (k == 0) ? 8'hFB : 8'hFF; dpIn = 8'h00;
      @(negedge clk);
      load = 1'b0;
      waitReady(ok);
      nTests++;
      if (!ok) begin nFail++; $display("[TB] FAIL blank_swap_timeout: got ready=%b, want 1", ready); end
      for (int i = 0; i < SCAN; i++) begin
        @(negedge clk);
        calcExp(); nTests++;
        if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
          nFail++;
          $display("[TB] FAIL blank_scan t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
        end
        if (curDigit() == 2 && curPhase() == 6) begin
          nTests++;
          if (k == 0 && an !== 8'hFF) begin
            nFail++; $display("[TB] FAIL blank_disabled: got an=%h, want FF", an);
          end else if (k == 1 && (an !== 8'hFB || seg !== 7'h7F)) begin
            nFail++; $display("[TB] FAIL blank_nibbleA: got an=%h seg=%h, want FB 7F", an, seg);
          end
        end
      end
    end
  endtask

  task automatic test_handshake();
    bit done;
    load = 1'b1; value = 32'h1111_2222; digitEn = 8'hFF; dpIn = 8'h00;
    @(negedge clk);
    nTests++;
    if (ready !== 1'b0) begin nFail++; $display("[TB] FAIL hs_ready_low: got ready=%b, want 0", ready); end
    value = 32'h9999_9999;
    @(negedge clk);
    load = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 3*SCAN && !done; i++) begin
      @(negedge clk);
      calcExp(); nTests++;
      if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
        nFail++;
        $display("[TB] FAIL hs_wait t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
      end
      if (ready === 1'b1) begin
        done = 1'b1;
        nTests++;
        if ((mT % SCAN) != 0) begin nFail++; $display("[TB] FAIL hs_ready_timing: got scan pos %0d, want 0", mT % SCAN); end
      end
    end
    nTests++;
    if (!done) begin nFail++; $display("[TB] FAIL hs_timeout: got ready=%b, want 1", ready); end
    waitCycles(2);
    nTests++;
    if (an !== 8'hFE || seg !== 7'h24) begin nFail++; $display("[TB] FAIL hs_first_frame: got an=%h seg=%h, want FE 24", an, seg); end
  endtask

  task automatic test_tear();
    bit found, sawOld, done;
    found = 1'b0;
    for (int i = 0; i < 2*SCAN && !found; i++) begin
      @(negedge clk);
      if (curDigit() == 3 && curPhase() >= GUARD_LEN) found = 1'b1;
    end
    nTests++;
    if (!found) begin nFail++; $display("[TB] FAIL tear_seek: got digit %0d, want 3", curDigit()); end
    load = 1'b1; value = 32'h5555_5555; digitEn = 8'hFF; dpIn = 8'h00;
    sawOld = 1'b0; done = 1'b0;
    for (int i = 0; i < 2*SCAN && !done; i++) begin
      @(negedge clk);
      load = 1'b0;
      calcExp(); nTests++;
      if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
        nFail++;
        $display("[TB] FAIL tear_scan t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
      end
      if (!sawOld && curDigit() == 5 && curPhase() == 6) begin
        sawOld = 1'b1; nTests++;
        if (seg !== 7'h79) begin nFail++; $display("[TB] FAIL tear_old_kept: got seg=%h, want 79", seg); end
      end
      if (ready === 1'b1) done = 1'b1;
    end
    nTests++;
    if (!done) begin nFail++; $display("[TB] FAIL tear_timeout: got ready=%b, want 1", ready); end
    for (int i = 0; i < SCAN; i++) begin
      @(negedge clk);
      calcExp(); nTests++;
      if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
        nFail++;
        $display("[TB] FAIL tear_new t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
      end
      if (curDigit() == 5 && curPhase() == 6) begin
        nTests++;
        if (seg !== 7'h12) begin nFail++; $display("[TB] FAIL tear_new_shown: got seg=%h, want 12", seg); end
      end
    end
  endtask

  task automatic test_dp();
    bit ok;
    int dpLow, badDp;
    load = 1'b1; value = 32'h0000_0000; digitEn = 8'hFF; dpIn = 8'h01;
    @(negedge clk);
    load = 1'b0;
    waitReady(ok);
    nTests++;
    if (!ok) begin nFail++; $display("[TB] FAIL dp_swap_timeout: got ready=%b, want 1", ready); end
    dpLow = 0; badDp = 0;
    for (int i = 0; i < SCAN; i++) begin
      @(negedge clk);
      calcExp(); nTests++;
      if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
        nFail++;
        $display("[TB] FAIL dp_scan t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
      end
      if (dp === 1'b0) dpLow++;
      if ((dp === 1'b0) != (an === 8'hFE)) badDp++;
    end
    nTests++;
    if (dpLow != DIGIT_LEN) begin nFail++; $display("[TB] FAIL dp_count: got %0d cycles, want %0d", dpLow, DIGIT_LEN); end
    nTests++;
    if (badDp != 0) begin nFail++; $display("[TB] FAIL dp_only_digit0: got %0d bad cycles, want 0", badDp); end
  endtask

  task automatic test_reset_mid();
    int litCycles;
    load = 1'b1; value = 32'h2468_0246; digitEn = 8'hFF; dpIn = 8'hAA;
    @(negedge clk);
    load = 1'b0;
    waitCycles(20);
    rst = 1'b1;
    #1;
    nTests++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL rst_async: got an=%h seg=%h dp=%b ready=%b, want an=FF seg=7F dp=1 ready=1", an, seg, dp, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    litCycles = 0;
    for (int i = 0; i < SCAN + 20; i++) begin
      @(negedge clk);
      calcExp(); nTests++;
      if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
        nFail++;
        $display("[TB] FAIL rst_scan t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
      end
      if (an !== 8'hFF) litCycles++;
    end
    nTests++;
    if (litCycles != 0) begin nFail++; $display("[TB] FAIL rst_pending_lost: got %0d lit cycles, want 0", litCycles); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      calcExp(); nTests++;
      if (an !== expAn || seg !== expSeg || dp !== expDp || ready !== expReady) begin
        nFail++;
        $display("[TB] FAIL random t=%0d: got an=%h seg=%h dp=%b ready=%b, want an=%h seg=%h dp=%b ready=%b", mT, an, seg, dp, ready, expAn, expSeg, expDp, expReady);
      end
      load    = ($urandom_range(0, 11) == 0);
      value   = $urandom;
      digitEn = 8'($urandom);
      dpIn    = 8'($urandom);
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_blank();
    test_handshake();
    test_tear();
    test_dp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
